// File: rtl/frame_windower.sv
// frame_windower
//   Reads one window of WIN_LENGTH samples from the framing buffer and
//   multiplies each sample by a coefficient from an external ROM. The
//   product is rounded half-up and saturated. The windowed frame is
//   streamed out with first/last markers. A frame starts only when en,
//   buf_avail and out_ready are all high in IDLE. Reads stall while the
//   buffer reports empty.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en                allow new frames (looked at in IDLE only)
//   buf_avail         buffer holds at least one window
//   buf_empty         buffer empty, blocks reads
//   buf_rd_en         buffer read strobe (data returns next cycle)
//   buf_dout          buffer read data
//   frm_init          one-cycle frame-start pulse to the buffer
//   coef_addr         coefficient ROM address, issued with buf_rd_en
//   coef_data         coefficient ROM data (1-cycle latency)
//   out_ready         downstream accepts a full frame (looked at in IDLE)
//   out_valid/data    windowed sample stream
//   out_first/last    markers for index 0 / WIN_LENGTH-1
//   busy              FSM not in IDLE
//   frame_cnt         completed frames, wrapping
module frame_windower #(
  parameter int WIDTH      = 32,
  parameter int COEF_W     = 16,
  parameter int WIN_LENGTH = 480,
  parameter int IDX_W      = $clog2(WIN_LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              buf_avail,
  input  logic              buf_empty,
  output logic              buf_rd_en,
  input  logic [WIDTH-1:0]  buf_dout,
  output logic              frm_init,
  output logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int PW = WIDTH + COEF_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LENGTH - 1);
  localparam logic signed [PW-1:0] RND_BIAS =
    {{(PW-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drain_q, drain_d;

  // Stage 1 tag: the buffer and ROM register the data themselves, so only
  // the valid bit and index travel alongside them here.
  logic             s1_vld_q;
  logic [IDX_W-1:0] s1_idx_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_first_q;
  logic             out_last_q;
  logic [15:0]      frame_cnt_q;

  logic signed [WIDTH+COEF_W-1:0] prod;
  logic signed [PW-1:0]           rnd;
  logic signed [PW-1:0]           shr;
  logic [WIDTH-1:0]               sat;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  // FSM next state and read control
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    buf_rd_en = 1'b0;
    frm_init  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && buf_avail && out_ready) state_d = INIT;
      end
      INIT: begin
        frm_init = 1'b1;
        idx_d    = '0;
        state_d  = READ;
      end
      READ: begin
        if (!buf_empty) begin
          buf_rd_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        // Two cycles: the last read's data sits in stage 1, then on the output.
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign coef_addr = idx_q;
  assign busy      = (state_q != IDLE);

  // Windowing arithmetic: full signed product, round half-up, saturate.
  always_comb begin
    prod = $signed(buf_dout) * $signed(coef_data);
    rnd  = PW'(prod) + RND_BIAS;
    shr  = rnd >>> (COEF_W - 1);
    if (shr > SAT_MAX) begin
      sat = SAT_MAX[WIDTH-1:0];
    end else if (shr < SAT_MIN) begin
      sat = SAT_MIN[WIDTH-1:0];
    end else begin
      sat = shr[WIDTH-1:0];
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      s1_vld_q    <= buf_rd_en;
      s1_idx_q    <= idx_q;
      out_valid_q <= s1_vld_q;
      out_first_q <= s1_vld_q && (s1_idx_q == '0);
      out_last_q  <= s1_vld_q && (s1_idx_q == LAST_IDX);
      if (s1_vld_q) out_data_q <= sat;
      // Counter changes on the same edge that raises out_last.
      if (s1_vld_q && (s1_idx_q == LAST_IDX)) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule
